fmap_pad_streamer: RTL
======================

// Module: fmap_pad_streamer
// PURPOSE
//   Reads one IMG_WIDTH x IMG_WIDTH 8-bit feature map from a synchronous-read frame memory.
//   Emits it as a zero-padded raster stream of (IMG_WIDTH+2)^2 beats, one beat per out_en pulse.
//   This is the producer side of the 3x3 sliding-window stage, whose row/col counters advance once per
//   en and expect exactly this padded order: row 0 and row IMG_WIDTH+1 all zero, and col 0 and
//   col IMG_WIDTH+1 zero on every row.
//   Sits between the feature-map RAM and the window/conv pipeline; supports downstream stall via out_ready.
// PARAMETERS
//   IMG_WIDTH  128  square image side in pixels; PAD_WIDTH = IMG_WIDTH+2
//   DATA_W     8    pixel width
//   ADDR_W     14   frame-memory address width; must be >= clog2(IMG_WIDTH*IMG_WIDTH)
// PORTS
//   clk          in   1       clock
//   rst          in   1       synchronous, active-high reset
//   start        in   1       begin one frame; sampled only in IDLE
//   busy         out  1       frame in progress
//   done         out  1       1-cycle pulse after the last beat is transferred
//   mem_rd_en    out  1       frame-memory read strobe
//   mem_addr     out  ADDR_W  read address, (r-1)*IMG_WIDTH+(c-1)
//   mem_rd_data  in   DATA_W  read data, valid exactly 1 cycle after mem_rd_en
//   out_ready    in   1       downstream may accept a beat this cycle
//   out_en       out  1       beat transferred this cycle (drives the window's en)
//   out_data     out  DATA_W  beat pixel, valid when out_en=1
//   out_last     out  1       with out_en, marks beat (PAD_WIDTH-1, PAD_WIDTH-1)
// BEHAVIOUR
//   Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_en=0, out_data=0, out_last=0.
//     Reset also sets FSM=IDLE, clears counters, flushes the FIFO and drops in-flight reads.
//   FSM states and transitions:
//     IDLE -> ISSUE on start=1; start in any other state is ignored.
//     ISSUE: walks (r,c) over 0..PAD_WIDTH-1 in raster order, c fastest; c wraps to 0 and r increments.
//     ISSUE -> DRAIN after coordinate (PAD_WIDTH-1, PAD_WIDTH-1) is issued.
//     DRAIN -> DONE once the FIFO is empty and no read is in flight.
//     DONE -> IDLE after one cycle; done=1 in DONE only.
//   busy=1 in ISSUE, DRAIN and DONE.
//   Issue stage:
//     Interior coordinate (1<=r,c<=IMG_WIDTH): mem_rd_en=1, mem_addr=(r-1)*IMG_WIDTH+(c-1).
//       The data word returned one cycle later is pushed into the FIFO.
//     Padding coordinate: mem_rd_en=0. A zero is pushed through the same 1-cycle slot, so order is preserved.
//   Output FIFO and flow control:
//     2-entry output FIFO; out_en = fifo_not_empty & out_ready; out_data/out_last = FIFO head.
//     Head is registered: no combinational path from mem_rd_data to out_data.
//     Issue is allowed in a cycle only if (fifo_count + inflight - pop) < 2.
//       This credit rule never overflows the FIFO and sustains 1 beat/cycle when out_ready stays high.
//     out_ready=0 stalls: no beat lost, duplicated or reordered; the coordinate counters hold.
//   Latency: start high at cycle T with out_ready held high gives first out_en at T+3.
//     Subsequent beats follow back-to-back, PAD_WIDTH^2 beats in total.
//   Completion: done pulses 1 cycle after the out_last transfer; busy falls with done.
//     A new start is then accepted in IDLE on the cycle after done.
//   Counter and arithmetic widths:
//     r and c are clog2(PAD_WIDTH+1) bits wide.
//     Address product is computed at ADDR_W bits with no truncation for the legal parameter range.
//   Reset mid-frame: the frame is abandoned immediately; no further out_en; next start restarts at (0,0).
// TESTING
//   T1 IMG_WIDTH=4, mem[a]=a+1, out_ready=1, start pulse:
//      36 beats 0,0,0,0,0,0, 0,1,2,3,4,0, 0,5,6,7,8,0, ..., 0,13,14,15,16,0, 0,0,0,0,0,0.
//      out_last on beat 36; done 1 cycle later; first out_en 3 cycles after start.
//   T2 same as T1 with mem_addr monitored: exactly 16 reads, addresses 0..15 strictly increasing, none on padding coordinates.
//   T3 same as T1 with out_ready driven by pseudo-random pattern (~50%, including runs of 5 lows):
//      identical 36-value sequence; FIFO never exceeds 2 entries; done only after beat 36.
//   T4 start re-asserted during ISSUE and DRAIN: ignored; exactly one frame of 36 beats and one done pulse.
//   T5 rst asserted at beat 20 for 1 cycle, then start:
//      no out_en during or after reset until restart; the full 36-beat sequence then restarts from beat 1.
//   T6 IMG_WIDTH=128 into the 3x3 window stage, stride 1, out_ready=1:
//      16900 out_en; window valid count = 128*128; done asserted once.

Source files
------------

// File: rtl/fmap_pad_streamer_if.sv
// Handshake and frame-memory bundle for the padded feature-map streamer.
// The master side is the streamer; the slave side is the memory plus the downstream consumer.
interface fmap_pad_streamer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 14
) ();
  logic              start;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_ready;
  logic              out_en;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_addr, out_en, out_data, out_last
  );

  modport slave (
    output start, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_addr, out_en, out_data, out_last
  );
endinterface

// File: rtl/fmap_pad_streamer.sv
// Streams one IMG_WIDTH^2 feature map as a zero-padded (IMG_WIDTH+2)^2 raster, one beat per out_en.
// Reads go through a 1-cycle slot into a 2-entry registered FIFO, throttled by a credit check.
module fmap_pad_streamer #(
  parameter int unsigned IMG_WIDTH = 128,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 14
) (
  input logic                clk,
  input logic                rst,
  fmap_pad_streamer_if.master bus
);
  localparam int unsigned     PadWidth = IMG_WIDTH + 2;
  localparam int unsigned     CntW     = $clog2(PadWidth + 1);
  localparam logic [CntW-1:0] LastIdx  = CntW'(PadWidth - 1);
  localparam logic [CntW-1:0] ImgMax   = CntW'(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] ImgW   = ADDR_W'(IMG_WIDTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   row_q, col_q;
  logic              inflight_q, infl_pad_q, infl_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              interior, last_coord, pop, credit_ok, issue, empty_after;
  logic [ADDR_W-1:0] row_m1, col_m1, rd_addr;

  always_comb begin
    interior   = (row_q != '0) && (row_q <= ImgMax) && (col_q != '0) && (col_q <= ImgMax);
    last_coord = (row_q == LastIdx) && (col_q == LastIdx);
    pop        = (count_q != 2'd0) && bus.out_ready && !rst;
    // Occupancy after this cycle's pop plus the slot already in flight must leave room.
    credit_ok  = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    issue      = (state_q == StIssue) && credit_ok && !rst;
    row_m1     = ADDR_W'(row_q) - ADDR_W'(1);
    col_m1     = ADDR_W'(col_q) - ADDR_W'(1);
    rd_addr    = interior ? (row_m1 * ImgW + col_m1) : '0;
    empty_after = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.mem_rd_en = issue && interior;
  assign bus.mem_addr  = rd_addr;
  assign bus.out_en    = pop;
  assign bus.out_data  = fifo_data_q[rd_ptr_q];
  assign bus.out_last  = fifo_last_q[rd_ptr_q] && (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      row_q          <= '0;
      col_q          <= '0;
      inflight_q     <= 1'b0;
      infl_pad_q     <= 1'b0;
      infl_last_q    <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      inflight_q  <= issue;
      infl_pad_q  <= !interior;
      infl_last_q <= last_coord;
      // Padding beats use the same slot as reads so raster order is kept.
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= infl_pad_q ? '0 : bus.mem_rd_data;
        fifo_last_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q              <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StIssue;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        StIssue: begin
          if (issue) begin
            if (last_coord) begin
              state_q <= StDrain;
            end else if (col_q == LastIdx) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDrain: if (empty_after) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
